// File: rtl/sram_arbiter.sv
// Two-port SRAM access arbiter: round-robin grant between the CPU and debug
// requesters, multi-cycle OE/WE sequencing, per-owner read data and done pulse.
module sram_arbiter #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16,
  parameter int RD_CYCLES = 4,
  parameter int WR_CYCLES = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic              busy,
  output logic              grant_dbg
);

  localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_we;
  logic              r_owner;
  logic              r_last_dbg;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;

  logic              w_any_req;
  logic              w_pick_dbg;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_cnt_zero;

  // On a tie the port that was not granted last wins.
  assign w_any_req   = cpu_req | dbg_req;
  assign w_pick_dbg  = dbg_req & (~cpu_req | ~r_last_dbg);
  assign w_sel_we    = w_pick_dbg ? dbg_we    : cpu_we;
  assign w_sel_addr  = w_pick_dbg ? dbg_addr  : cpu_addr;
  assign w_sel_wdata = w_pick_dbg ? dbg_wdata : cpu_wdata;
  assign w_cnt_zero  = (r_cnt == '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_any_req) w_next = ST_ACCESS;
      ST_ACCESS: if (w_cnt_zero) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_we        <= 1'b0;
      r_owner     <= 1'b0;
      r_last_dbg  <= 1'b1;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_pick_dbg;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_cnt   <= w_sel_we ? WR_LOAD : RD_LOAD;
          end
        end
        ST_ACCESS: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!r_we) begin
            if (r_owner) r_dbg_rdata <= sram_rdata;
            else         r_cpu_rdata <= sram_rdata;
          end
        end
        ST_DONE: r_last_dbg <= r_owner;
        default: ;
      endcase
    end
  end

  // Strobes decode from state and latched registers only, so reset drops them at once.
  assign Mem_OE     = (r_state == ST_ACCESS) & ~r_we;
  assign Mem_WE     = (r_state == ST_ACCESS) &  r_we;
  assign cpu_done   = (r_state == ST_DONE) & ~r_owner;
  assign dbg_done   = (r_state == ST_DONE) &  r_owner;
  assign busy       = (r_state != ST_IDLE);
  assign grant_dbg  = r_owner;
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;
  assign cpu_rdata  = r_cpu_rdata;
  assign dbg_rdata  = r_dbg_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: a transaction-level model predicts grants,
// data and timing; a negedge monitor checks every done pulse and strobe invariants.
module tb_sram_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int RD = 4;
  localparam int WR = 4;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr, sram_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, sram_wdata, sram_rdata;
  logic          cpu_done, dbg_done, Mem_OE, Mem_WE, busy, grant_dbg;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_CYCLES(RD), .WR_CYCLES(WR)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .busy(busy), .grant_dbg(grant_dbg)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // SRAM device: unwritten locations return a fixed address-derived pattern.
  function automatic logic [15:0] init_val(input logic [7:0] a);
    return 16'h1234 + {8'h00, a} - 16'h0010;
  endfunction

  logic [DW-1:0] dev_mem [256];
  bit            dev_wr  [256];
  always @(posedge Clk) begin
    if (Mem_WE) begin
      dev_mem[sram_addr[7:0]] <= sram_wdata;
      dev_wr[sram_addr[7:0]]  <= 1'b1;
    end
  end
  assign sram_rdata = dev_wr[sram_addr[7:0]] ? dev_mem[sram_addr[7:0]] : init_val(sram_addr[7:0]);

  typedef struct {
    logic          owner;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] cpu_rd;
    logic [DW-1:0] dbg_rd;
  } exp_t;
  exp_t q[$];

  // Reference model state
  logic [DW-1:0] ref_mem [256];
  logic          m_last;
  logic [DW-1:0] m_cpu, m_dbg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor
  int oe_n = 0, we_n = 0, b_n = 0;
  always @(negedge Clk) begin
    if (Reset) begin
      check("strobe_excl", 32'(Mem_OE & Mem_WE), 32'd0);
      if (!busy) begin
        check("strobe_idle", 32'(Mem_OE | Mem_WE), 32'd0);
        check("done_idle", 32'(cpu_done | dbg_done), 32'd0);
        oe_n = 0; we_n = 0; b_n = 0;
      end else begin
        if (Mem_OE) oe_n++;
        if (Mem_WE) we_n++;
        b_n++;
        if (q.size() > 0) check("addr_hold", 32'(sram_addr), 32'(q[0].addr));
        if (cpu_done | dbg_done) begin
          if (q.size() == 0) fail_now("unexpected_done");
          else begin
            exp_t e;
            e = q.pop_front();
            check("done_owner", {30'd0, cpu_done, dbg_done}, e.owner ? 32'd1 : 32'd2);
            check("grant_dbg", 32'(grant_dbg), 32'(e.owner));
            if (e.we) check("sram_wdata", 32'(sram_wdata), 32'(e.wdata));
            check("oe_cycles", 32'(oe_n), e.we ? 32'd0 : 32'(RD));
            check("we_cycles", 32'(we_n), e.we ? 32'(WR) : 32'd0);
            check("latency", 32'(b_n), e.we ? 32'(WR + 1) : 32'(RD + 1));
            check("cpu_rdata", 32'(cpu_rdata), 32'(e.cpu_rd));
            check("dbg_rdata", 32'(dbg_rdata), 32'(e.dbg_rd));
          end
        end
      end
    end
  end

  task automatic drive_idle();
    cpu_req = 1'b0; dbg_req = 1'b0;
  endtask

  task automatic issue(input logic c, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input logic d, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                       input bit garbage, output int done_cyc);
    exp_t e;
    bit   seen;
    cpu_req = c; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = d; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    e.owner = (c && d) ? ~m_last : d;
    e.we    = e.owner ? dw : cw;
    e.addr  = e.owner ? da : ca;
    e.wdata = e.owner ? dd : cd;
    if (e.we) ref_mem[e.addr[7:0]] = e.wdata;
    else if (e.owner) m_dbg = ref_mem[e.addr[7:0]];
    else m_cpu = ref_mem[e.addr[7:0]];
    e.cpu_rd = m_cpu;
    e.dbg_rd = m_dbg;
    m_last = e.owner;
    q.push_back(e);
    done_cyc = -1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge Clk);
      seen = busy;
    end
    if (!seen) begin fail_now("grant_timeout"); q.delete(); return; end
    if (garbage) begin
      @(negedge Clk);
      cpu_req = 1'b0; cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
      dbg_req = 1'($urandom_range(0, 1)); dbg_we = 1'($urandom_range(0, 1));
      dbg_addr = AW'($urandom); dbg_wdata = DW'($urandom);
    end
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (cpu_done | dbg_done) seen = 1;
      else @(negedge Clk);
    end
    if (!seen) begin fail_now("done_timeout"); q.delete(); return; end
    done_cyc = cyc;
  endtask

  initial begin
    int t0, t1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    m_last = 1'b1; m_cpu = '0; m_dbg = '0;
    cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    drive_idle();
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_dbg), 32'd0);
    check("rst_strobes", 32'({Mem_OE, Mem_WE}), 32'd0);
    check("rst_rdata", 32'({cpu_rdata, dbg_rdata}), 32'd0);
    check("rst_sram", 32'(sram_addr) | 32'(sram_wdata), 32'd0);
    Reset = 1'b1;
    @(negedge Clk);

    // CPU read of 0x00010 returns 0x1234
    issue(1, 0, 20'h00010, 16'h0, 0, 0, 20'h0, 16'h0, 0, t0);
    check("dir_cpu_rdata", 32'(cpu_rdata), 32'h1234);
    drive_idle();
    repeat (2) @(negedge Clk);

    // Debug write 0x0003F <= 0xBEEF
    issue(0, 0, 20'h0, 16'h0, 1, 1, 20'h0003F, 16'hBEEF, 0, t0);
    check("dir_dbg_waddr", 32'(sram_addr), 32'h3F);
    drive_idle();
    @(negedge Clk);

    // Both held: alternating grants, 6 cycles per access
    issue(1, 0, 20'h00003, 16'h0, 1, 0, 20'h00004, 16'h0, 0, t0);
    for (int k = 0; k < 3; k++) begin
      issue(1, 0, 20'h00003, 16'h0, 1, 0, 20'h00004, 16'h0, 0, t1);
      check("rr_period", 32'(t1 - t0), 32'd6);
      t0 = t1;
    end
    drive_idle();
    repeat (2) @(negedge Clk);

    // CPU read with req dropped and address changed mid-access
    issue(1, 0, 20'h00005, 16'h0, 0, 0, 20'h0, 16'h0, 1, t0);
    drive_idle();
    repeat (2) @(negedge Clk);

    // Reset during cycle 3 of a debug write
    dbg_req = 1; dbg_we = 1; dbg_addr = 20'h000FF; dbg_wdata = 16'hCAFE;
    t0 = 0;
    while (!busy && t0 < 10) begin @(negedge Clk); t0++; end
    dbg_req = 0;
    repeat (2) @(negedge Clk);
    check("pre_rst_we", 32'(Mem_WE), 32'd1);
    #2 Reset = 1'b0;
    #1;
    check("async_we", 32'(Mem_WE), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'({cpu_done, dbg_done}), 32'd0);
    check("async_rdata", 32'({cpu_rdata, dbg_rdata}), 32'd0);
    check("async_addr", 32'(sram_addr), 32'd0);
    m_last = 1'b1; m_cpu = '0; m_dbg = '0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    issue(1, 0, 20'h00006, 16'h0, 1, 0, 20'h00007, 16'h0, 0, t0);
    check("post_rst_tie", 32'(grant_dbg), 32'd0);

    // Random mixed traffic
    for (int n = 0; n < 200; n++) begin
      logic c, d;
      c = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      if (!c && !d) c = 1'b1;
      issue(c, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
            d, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
            bit'($urandom_range(0, 1)), t0);
      if ($urandom_range(0, 3) == 0) begin
        drive_idle();
        repeat ($urandom_range(1, 3)) @(negedge Clk);
      end
    end
    drive_idle();
    repeat (10) @(negedge Clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
